// File: rtl/game_state_regs.sv
// game_state_regs: score/fruit storage, lives tracking with post-hit
// invincibility, and a sequential double-dabble score-to-BCD converter
// for the HUD.
// Optional feature macro: GAME_REGS_HISCORE_EN. When it is defined, the
// block tracks the highest score loaded since Reset. When it is undefined,
// high_score is tied to 0.
module game_state_regs #(
    parameter int SCORE_W      = 10,
    parameter int LIVES_W      = 2,
    parameter int LIVES_INIT   = 3,
    parameter int HIT_COOLDOWN = 50_000_000
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Load_S,
    input  logic [SCORE_W-1:0] score_to_reg,
    input  logic               Load_F,
    input  logic [3:0]         fruits_to_reg,
    input  logic               restart,
    input  logic               lifeDown,
    output logic [SCORE_W-1:0] score_from_reg,
    output logic [3:0]         fruits_from_reg,
    output logic [LIVES_W-1:0] lives,
    output logic               invincible,
    output logic               out_of_lives,
    output logic [15:0]        score_bcd,
    output logic               bcd_valid,
    output logic [SCORE_W-1:0] high_score
);

    localparam int CNT_W  = (HIT_COOLDOWN > 1) ? $clog2(HIT_COOLDOWN) : 1;
    localparam int STEP_W = $clog2(SCORE_W + 1);
    localparam logic [CNT_W-1:0]   CNT_LOAD   = CNT_W'(HIT_COOLDOWN - 1);
    localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(SCORE_W - 1);
    localparam logic [LIVES_W-1:0] LIVES_LOAD = LIVES_W'(LIVES_INIT);

    typedef enum logic [1:0] {L_ALIVE, L_COOL, L_DEAD} lives_state_t;
    typedef enum logic {B_IDLE, B_SHIFT} bcd_state_t;

    // ---------------------------------------------------------------
    // Score and fruit storage
    // ---------------------------------------------------------------
    logic [SCORE_W-1:0] score_q;
    logic [3:0]         fruits_q;

    // Independent load strobes for the score and fruit registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            score_q  <= '0;
            fruits_q <= '0;
        end else begin
            if (Load_S) score_q  <= score_to_reg;
            if (Load_F) fruits_q <= fruits_to_reg;
        end
    end

    assign score_from_reg  = score_q;
    assign fruits_from_reg = fruits_q;

    // ---------------------------------------------------------------
    // Lives FSM with hit cooldown
    // ---------------------------------------------------------------
    lives_state_t       lstate_q, lstate_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ool_q, ool_d;
    logic               life_prev_q;
    logic               life_edge;

    // lifeDown is a level; only its rising edge counts as a hit
    assign life_edge = lifeDown & ~life_prev_q;

    // Lives state, counter and edge-detect registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            lstate_q    <= L_ALIVE;
            lives_q     <= LIVES_LOAD;
            cnt_q       <= '0;
            ool_q       <= 1'b0;
            life_prev_q <= 1'b0;
        end else begin
            lstate_q    <= lstate_d;
            lives_q     <= lives_d;
            cnt_q       <= cnt_d;
            ool_q       <= ool_d;
            life_prev_q <= lifeDown;
        end
    end

    // Next-state logic: restart wins over a simultaneous hit
    always_comb begin
        lstate_d = lstate_q;
        lives_d  = lives_q;
        cnt_d    = cnt_q;
        ool_d    = ool_q;
        if (restart) begin
            lstate_d = L_ALIVE;
            lives_d  = LIVES_LOAD;
            cnt_d    = '0;
            ool_d    = 1'b0;
        end else begin
            case (lstate_q)
                L_ALIVE: begin
                    if (life_edge) begin
                        if (lives_q <= LIVES_W'(1)) begin
                            // last life gone; clamp at zero
                            lives_d  = '0;
                            lstate_d = L_DEAD;
                            ool_d    = 1'b1;
                        end else begin
                            lives_d  = lives_q - LIVES_W'(1);
                            lstate_d = L_COOL;
                            cnt_d    = CNT_LOAD;
                        end
                    end
                end
                L_COOL: begin
                    if (cnt_q == '0) begin
                        lstate_d = L_ALIVE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                L_DEAD: begin
                    lives_d = '0;
                end
                default: begin
                    lstate_d = L_ALIVE;
                end
            endcase
        end
    end

    assign lives        = lives_q;
    assign invincible   = (lstate_q == L_COOL);
    assign out_of_lives = ool_q;

    // ---------------------------------------------------------------
    // Sequential double-dabble converter
    // ---------------------------------------------------------------
    bcd_state_t         bstate_q, bstate_d;
    logic [SCORE_W-1:0] shreg_q, shreg_d;
    logic [15:0]        acc_q, acc_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [15:0]        bcd_q, bcd_d;
    logic               valid_q, valid_d;
    logic [15:0]        acc_adj;
    logic [15:0]        acc_shift;

    // Add 3 to every digit of 5 or more before the shift
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dabble
            assign acc_adj[gi*4 +: 4] = (acc_q[gi*4 +: 4] >= 4'd5) ?
                                        (acc_q[gi*4 +: 4] + 4'd3) :
                                        acc_q[gi*4 +: 4];
        end
    endgenerate

    assign acc_shift = {acc_adj[14:0], shreg_q[SCORE_W-1]};

    // Converter state and result registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bstate_q <= B_IDLE;
            shreg_q  <= '0;
            acc_q    <= '0;
            step_q   <= '0;
            bcd_q    <= 16'h0000;
            valid_q  <= 1'b1;
        end else begin
            bstate_q <= bstate_d;
            shreg_q  <= shreg_d;
            acc_q    <= acc_d;
            step_q   <= step_d;
            bcd_q    <= bcd_d;
            valid_q  <= valid_d;
        end
    end

    // A new Load_S always restarts the conversion; the result is published
    // only on the final shift, so an aborted run never shows as valid
    always_comb begin
        bstate_d = bstate_q;
        shreg_d  = shreg_q;
        acc_d    = acc_q;
        step_d   = step_q;
        bcd_d    = bcd_q;
        valid_d  = valid_q;
        if (Load_S) begin
            shreg_d  = score_to_reg;
            acc_d    = '0;
            step_d   = '0;
            valid_d  = 1'b0;
            bstate_d = B_SHIFT;
        end else if (bstate_q == B_SHIFT) begin
            acc_d   = acc_shift;
            shreg_d = {shreg_q[SCORE_W-2:0], 1'b0};
            step_d  = step_q + STEP_W'(1);
            if (step_q == STEP_LAST) begin
                bcd_d    = acc_shift;
                valid_d  = 1'b1;
                bstate_d = B_IDLE;
            end
        end
    end

    assign score_bcd = bcd_q;
    assign bcd_valid = valid_q;

    // ---------------------------------------------------------------
    // High score
    // ---------------------------------------------------------------
`ifdef GAME_REGS_HISCORE_EN
    logic [SCORE_W-1:0] hs_q;

    // Keep the largest score loaded since Reset; restart leaves it alone
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hs_q <= '0;
        end else if (Load_S && (score_to_reg > hs_q)) begin
            hs_q <= score_to_reg;
        end
    end

    assign high_score = hs_q;
`else
    assign high_score = '0;
`endif

endmodule
